// File: rtl/render_pipeline_pkg.sv
// Shared definitions for the render pipeline: primitive assembler state
// encoding and the width of the signed triangle area.
package render_pipeline_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_INDEX,
    WAIT_INDEX,
    READ_VERTEX,
    WAIT_VERTEX,
    CULL,
    EMIT,
    DONE
  } pa_cull_state_t;

  // Two guard bits let the edge-function difference of products fit exactly.
  localparam int PA_AREA_GUARD_BITS = 2;
  localparam int PA_AREA_W_DEFAULT  = 2 * 12 + PA_AREA_GUARD_BITS;

  function automatic int pa_area_width(input int data_w);
    return 2 * data_w + PA_AREA_GUARD_BITS;
  endfunction

endpackage

// File: rtl/triangle_cull_test.sv
// Trivial-reject and winding test for one triangle; the decision is captured
// on load so it is ready in the cycle after the vertices arrive.
module triangle_cull_test
  import render_pipeline_pkg::*;
#(
  parameter int DATAWIDTH     = 12,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 320,
  parameter int CULL_BACKFACE = 1,
  parameter int CULL_CW       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [2*DATAWIDTH-1:0]   i_v0_xy,
  input  logic [2*DATAWIDTH-1:0]   i_v1_xy,
  input  logic [2*DATAWIDTH-1:0]   i_v2_xy,
  input  logic                     i_inv0,
  input  logic                     i_inv1,
  input  logic                     i_inv2,
  output logic                     o_cull
);

  localparam int AREA_W = pa_area_width(DATAWIDTH);
  localparam logic signed [AREA_W-1:0] SW = AREA_W'(SCREEN_WIDTH);
  localparam logic signed [AREA_W-1:0] SH = AREA_W'(SCREEN_HEIGHT);

  function automatic logic signed [AREA_W-1:0] sext(input logic [DATAWIDTH-1:0] v);
    return {{(AREA_W-DATAWIDTH){v[DATAWIDTH-1]}}, v};
  endfunction

  logic signed [AREA_W-1:0] x0, y0, x1, y1, x2, y2;
  logic signed [AREA_W-1:0] area;
  logic off_screen, back_face, degenerate, any_inv;
  logic cull_d, cull_q;

  assign x0 = sext(i_v0_xy[DATAWIDTH-1:0]);
  assign y0 = sext(i_v0_xy[2*DATAWIDTH-1:DATAWIDTH]);
  assign x1 = sext(i_v1_xy[DATAWIDTH-1:0]);
  assign y1 = sext(i_v1_xy[2*DATAWIDTH-1:DATAWIDTH]);
  assign x2 = sext(i_v2_xy[DATAWIDTH-1:0]);
  assign y2 = sext(i_v2_xy[2*DATAWIDTH-1:DATAWIDTH]);

  always_comb begin
    area       = (x1 - x0) * (y2 - y0) - (x2 - x0) * (y1 - y0);
    any_inv    = i_inv0 | i_inv1 | i_inv2;
    off_screen = (x0[AREA_W-1] & x1[AREA_W-1] & x2[AREA_W-1]) |
                 ((x0 >= SW) & (x1 >= SW) & (x2 >= SW)) |
                 (y0[AREA_W-1] & y1[AREA_W-1] & y2[AREA_W-1]) |
                 ((y0 >= SH) & (y1 >= SH) & (y2 >= SH));
    degenerate = (area == '0);
    back_face  = 1'b0;
    if (CULL_BACKFACE != 0) begin
      // CCW-culling rejects negative area, CW-culling rejects positive area.
      if (CULL_CW != 0) back_face = !area[AREA_W-1] && !degenerate;
      else              back_face = area[AREA_W-1];
    end
    cull_d = cull_q;
    if (load) cull_d = any_inv | off_screen | degenerate | back_face;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cull_q <= 1'b0;
    else     cull_q <= cull_d;
  end

  assign o_cull = cull_q;

endmodule

// File: rtl/primitive_assembler_cull.sv
// Fetches indexed triangles, fetches their vertices, rejects culled ones and
// hands surviving primitives downstream with a valid/ready handshake.
module primitive_assembler_cull
  import render_pipeline_pkg::*;
#(
  parameter int DATAWIDTH          = 12,
  parameter int SCREEN_WIDTH       = 320,
  parameter int SCREEN_HEIGHT      = 320,
  parameter int MAX_VERTEX_COUNT   = 16384,
  parameter int MAX_TRIANGLE_COUNT = 16384,
  parameter int CULL_BACKFACE      = 1,
  parameter int CULL_CW            = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  output logic                                   o_ready,
  output logic                                   finished,
  output logic                                   o_index_read_en,
  input  logic [3*$clog2(MAX_VERTEX_COUNT)-1:0]  i_index_data,
  input  logic                                   i_index_dv,
  input  logic                                   i_index_last,
  output logic [3*$clog2(MAX_VERTEX_COUNT)-1:0]  o_vertex_addr,
  output logic                                   o_vertex_read_en,
  input  logic signed [3*DATAWIDTH-1:0]          i_v0,
  input  logic signed [3*DATAWIDTH-1:0]          i_v1,
  input  logic signed [3*DATAWIDTH-1:0]          i_v2,
  input  logic                                   i_v0_invalid,
  input  logic                                   i_v1_invalid,
  input  logic                                   i_v2_invalid,
  input  logic                                   i_vertex_dv,
  output logic signed [3*DATAWIDTH-1:0]          o_v0,
  output logic signed [3*DATAWIDTH-1:0]          o_v1,
  output logic signed [3*DATAWIDTH-1:0]          o_v2,
  output logic                                   o_dv,
  input  logic                                   i_ready,
  output logic                                   o_last,
  output logic [$clog2(MAX_TRIANGLE_COUNT):0]    o_emitted_count,
  output logic [$clog2(MAX_TRIANGLE_COUNT):0]    o_culled_count
);

  localparam int VA_W  = $clog2(MAX_VERTEX_COUNT);
  localparam int CNT_W = $clog2(MAX_TRIANGLE_COUNT) + 1;
  localparam int V_W   = 3 * DATAWIDTH;

  pa_cull_state_t          state_q, state_d;
  logic [3*VA_W-1:0]       vaddr_q, vaddr_d;
  logic                    last_q, last_d;
  logic signed [V_W-1:0]   v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [CNT_W-1:0]        emitted_q, emitted_d, culled_q, culled_d;
  logic                    cull_load, cull_hit;

  triangle_cull_test #(
    .DATAWIDTH     (DATAWIDTH),
    .SCREEN_WIDTH  (SCREEN_WIDTH),
    .SCREEN_HEIGHT (SCREEN_HEIGHT),
    .CULL_BACKFACE (CULL_BACKFACE),
    .CULL_CW       (CULL_CW)
  ) u_cull (
    .clk     (clk),
    .rst     (rst),
    .load    (cull_load),
    .i_v0_xy (i_v0[2*DATAWIDTH-1:0]),
    .i_v1_xy (i_v1[2*DATAWIDTH-1:0]),
    .i_v2_xy (i_v2[2*DATAWIDTH-1:0]),
    .i_inv0  (i_v0_invalid),
    .i_inv1  (i_v1_invalid),
    .i_inv2  (i_v2_invalid),
    .o_cull  (cull_hit)
  );

  always_comb begin
    state_d   = state_q;
    vaddr_d   = vaddr_q;
    last_d    = last_q;
    v0_d      = v0_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    emitted_d = emitted_q;
    culled_d  = culled_q;
    cull_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ_INDEX;
          emitted_d = '0;
          culled_d  = '0;
        end
      end
      READ_INDEX:  state_d = WAIT_INDEX;
      WAIT_INDEX: begin
        if (i_index_dv) begin
          vaddr_d = i_index_data;
          last_d  = i_index_last;
          state_d = READ_VERTEX;
        end
      end
      READ_VERTEX: state_d = WAIT_VERTEX;
      WAIT_VERTEX: begin
        // The cull decision is computed from the same inputs being captured.
        if (i_vertex_dv) begin
          v0_d      = i_v0;
          v1_d      = i_v1;
          v2_d      = i_v2;
          cull_load = 1'b1;
          state_d   = CULL;
        end
      end
      CULL: begin
        if (cull_hit) begin
          culled_d = culled_q + CNT_W'(1);
          state_d  = last_q ? DONE : READ_INDEX;
        end else begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (i_ready) begin
          emitted_d = emitted_q + CNT_W'(1);
          state_d   = last_q ? DONE : READ_INDEX;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vaddr_q   <= '0;
      last_q    <= 1'b0;
      v0_q      <= '0;
      v1_q      <= '0;
      v2_q      <= '0;
      emitted_q <= '0;
      culled_q  <= '0;
    end else begin
      state_q   <= state_d;
      vaddr_q   <= vaddr_d;
      last_q    <= last_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      emitted_q <= emitted_d;
      culled_q  <= culled_d;
    end
  end

  assign o_ready          = (state_q == IDLE);
  assign o_index_read_en  = (state_q == READ_INDEX);
  assign o_vertex_read_en = (state_q == READ_VERTEX);
  assign o_dv             = (state_q == EMIT);
  assign o_last           = (state_q == EMIT) && last_q;
  assign finished         = (state_q == DONE);
  assign o_vertex_addr    = vaddr_q;
  assign o_v0             = v0_q;
  assign o_v1             = v1_q;
  assign o_v2             = v2_q;
  assign o_emitted_count  = emitted_q;
  assign o_culled_count   = culled_q;

endmodule
